sigmoid_bwd: RTL
================

// Module: sigmoid_bwd
// PURPOSE
// - Backward-pass companion to the forward sigmoid activation.
// - Computes grad_out = grad_in * y * (1 - y). y is the sigmoid output saved from the forward pass; grad_in is the upstream gradient.
// - Sits in the training datapath after the loss and gradient chain. Streams one sample per cycle through a 4-stage pipeline with an ena/valid qualifier.
// PARAMETERS
// - DATA_W  16  width of y_in, grad_in and grad_out; signed fixed point <1,7,8>
// - FRAC_W   8  fractional bits. ONE = 1<<FRAC_W = 256.
// PORTS
// - clk       in   1       clock; all state on posedge
// - rst_n     in   1       asynchronous, active-low reset
// - ena       in   1       y_in/grad_in valid this cycle
// - y_in      in   DATA_W  signed forward sigmoid output, <1,7,8>
// - grad_in   in   DATA_W  signed upstream gradient, <1,7,8>
// - valid     out  1       grad_out holds a new result this cycle
// - grad_out  out  DATA_W  signed local gradient, <1,7,8>
// - stat_clr  in   1       (SIGMOID_BWD_STAT_EN only) sync clear of clamp_cnt
// - clamp_cnt out  16      (SIGMOID_BWD_STAT_EN only) count of clamped y samples
// BEHAVIOUR
// - Reset (async assert, sync release): all pipeline regs, stage-valid bits, valid, grad_out = 0.
//   - With the macro: clamp_cnt = 0.
// - Stage-valid shift reg v[3:0]: v <= {v[2:0], ena}; valid = v[3].
//   - Latency exactly 4 clks, ena to valid.
//   - Full throughput; gaps in ena appear as gaps in valid.
// - Each stage's data regs load only when that stage's valid bit is set, otherwise they hold.
//   - grad_out holds its last valid result while valid=0.
// - S1 (loads on ena):
//   - yc = clamp(y_in, 0, ONE), 9-bit unsigned; clamp flag set if y_in<0 or y_in>ONE.
//   - om = ONE - yc (9-bit unsigned).
//   - grad_in registered.
// - S2: d = (yc*om + 2^(FRAC_W-1)) >> FRAC_W.
//   - 18-bit product; result 7-bit unsigned, range 0..64 (max 0.25).
//   - grad and clamp flag delayed alongside.
// - S3: p = $signed(grad)*$signed({1'b0,d}); 24-bit signed.
//   - r = (p + 2^(FRAC_W-1)) >>> FRAC_W (round half up, arithmetic shift).
// - S4: grad_out <= r[DATA_W-1:0].
//   - No overflow is possible: |r| <= 8192.
// - Boundaries:
//   - y=0 or y=ONE gives d=0, so grad_out=0 for any grad_in.
//   - grad_in=-32768 is legal: gives -8192 at d=64.
// - Reset mid-stream: in-flight samples are discarded. valid stays 0 until 4 clks after the first ena after release.
// CONFIGURATION
// - `SIGMOID_BWD_STAT_EN defined: adds ports stat_clr and clamp_cnt.
//   - clamp_cnt increments when S1 loads a clamped sample; saturates at 16'hFFFF.
//   - stat_clr has priority over the increment (same cycle: result 0).
// - Not defined: ports and counter are absent; the clamp flag is not generated. Datapath identical.
// TESTING
// - Reset: hold rst_n=0 with ena=1 -> valid=0, grad_out=0. Release -> first valid exactly 4 clks after first ena sample.
// - y=128, g=256 -> d=64, grad_out=64 (0.25), valid 4 clks after ena.
// - y=64, g=-256 -> d=48, grad_out=-48. y=192, g=512 -> d=48, grad_out=96.
// - y=0/g=1000 and y=256/g=1000 -> grad_out=0.
//   - y=-50 and y=300 -> clamped, grad_out=0.
//   - With macro: clamp_cnt=2; stat_clr plus simultaneous clamp -> 0.
// - Stream ena=1 for 8 clks, 2-clk gap, 3 clks, each sample with distinct (y,g):
//   - valid is the ena pattern delayed 4.
//   - Outputs are in order and match the reference model.
//   - grad_out holds during the gap.
// - Assert rst_n=0 mid-stream with 3 samples in flight -> outputs clear immediately; no stale valid after release.

Source files
------------

// File: rtl/sigmoid_bwd.sv
// ============================================================================
// Module   : sigmoid_bwd
// Purpose  : 4-stage pipelined sigmoid backward pass, grad_out = grad_in*y*(1-y).
//            Optional clamp statistics under `SIGMOID_BWD_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sigmoid_bwd #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] grad_in,
  output logic              valid,
  output logic [DATA_W-1:0] grad_out
`ifdef SIGMOID_BWD_STAT_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       clamp_cnt
`endif
);

  localparam logic [FRAC_W:0]   C_ONE  = 9'(1 << FRAC_W);
  localparam logic [17:0]       C_HALF = 18'(1 << (FRAC_W - 1));
  localparam logic signed [23:0] C_HALF_S = 24'sd128;

  logic [3:0]        v_q;
  logic [FRAC_W:0]   yc1_q, om1_q;
  logic [DATA_W-1:0] g1_q, g2_q;
  logic [6:0]        d2_q;
  logic [DATA_W-1:0] r3_q;
  logic [DATA_W-1:0] grad_out_q;

  logic [FRAC_W:0]    yc_d;
  logic [FRAC_W:0]    om_d;
  logic [17:0]        sum_d;
  logic signed [23:0] p_d;
  logic signed [23:0] p_rnd_d;
  logic               y_neg_d;
  logic               y_big_d;

  assign y_neg_d = y_in[DATA_W-1];
  assign y_big_d = !y_in[DATA_W-1] && (y_in[DATA_W-2:0] > 15'(C_ONE));

  // Clamp y into [0, ONE]; anything outside the sigmoid range is a corrupt sample
  always_comb begin
    yc_d = y_in[FRAC_W:0];
    if (y_neg_d) begin
      yc_d = '0;
    end else if (y_big_d) begin
      yc_d = C_ONE;
    end
  end

  assign om_d    = C_ONE - yc_d;
  assign sum_d   = (yc1_q * om1_q) + C_HALF;
  assign p_d     = $signed(g2_q) * $signed({1'b0, d2_q});
  assign p_rnd_d = p_d + C_HALF_S;

  // y*(1-y) <= 0.25, so only bits [14:8] of the rounded product can be set
  logic unused_bits;
  assign unused_bits = ^{sum_d[17:15], sum_d[7:0], p_rnd_d[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q        <= '0;
      yc1_q      <= '0;
      om1_q      <= '0;
      g1_q       <= '0;
      d2_q       <= '0;
      g2_q       <= '0;
      r3_q       <= '0;
      grad_out_q <= '0;
    end else begin
      v_q <= {v_q[2:0], ena};
      if (ena) begin
        yc1_q <= yc_d;
        om1_q <= om_d;
        g1_q  <= grad_in;
      end
      if (v_q[0]) begin
        d2_q <= sum_d[14:8];
        g2_q <= g1_q;
      end
      if (v_q[1]) begin
        r3_q <= p_rnd_d[23:8];
      end
      if (v_q[2]) begin
        grad_out_q <= r3_q;
      end
    end
  end

  assign valid    = v_q[3];
  assign grad_out = grad_out_q;

`ifdef SIGMOID_BWD_STAT_EN
  logic        clamp_d;
  logic [15:0] clamp_cnt_q;

  assign clamp_d = y_neg_d || y_big_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clamp_cnt_q <= '0;
    end else if (stat_clr) begin
      clamp_cnt_q <= '0;
    end else if (ena && clamp_d && (clamp_cnt_q != 16'hFFFF)) begin
      clamp_cnt_q <= clamp_cnt_q + 16'd1;
    end
  end

  assign clamp_cnt = clamp_cnt_q;
`else
  logic unused_clamp;
  assign unused_clamp = y_neg_d ^ y_big_d;
`endif

endmodule

`default_nettype wire
